rect_fill_ctrl: RTL and testbench

- Command-driven sequencer for the VGA adapter pixel-write port (x, y, colour, plot).
- Accepts one rectangle-fill or clear-screen command through a valid/ready handshake.
- Clips the command to the screen and sweeps every covered pixel in raster order, one pixel per clock.
- Replaces the fixed full-screen fill statemachine/datapath pair, and lets game or test logic draw arbitrary boxes.

---
 rtl/rect_fill_ctrl.sv | 162 ++++++++++++++++
 tb/tb_rect_fill_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_fill_ctrl.sv
// Rectangle-fill / clear-screen sequencer for the VGA adapter pixel-write port.
// One command is accepted in IDLE, clipped to the screen, then swept in raster order.
module rect_fill_ctrl #(
  parameter int         SCREEN_WIDTH  = 160,
  parameter int         SCREEN_HEIGHT = 120,
  parameter logic [2:0] CLEAR_COLOUR  = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_clear,
  input  logic [7:0] cmd_x0,
  input  logic [6:0] cmd_y0,
  input  logic [7:0] cmd_w,
  input  logic [6:0] cmd_h,
  input  logic [2:0] cmd_colour,
  input  logic       hold,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CLIP = 2'd1;
  localparam logic [1:0] S_DRAW = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [8:0] X_LIM  = 9'(SCREEN_WIDTH);
  localparam logic [8:0] X_LAST = 9'(SCREEN_WIDTH - 1);
  localparam logic [7:0] Y_LIM  = 8'(SCREEN_HEIGHT);
  localparam logic [7:0] Y_LAST = 8'(SCREEN_HEIGHT - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] x0_q, x0_d;
  logic [6:0] y0_q, y0_d;
  logic [7:0] w_q, w_d;
  logic [6:0] h_q, h_d;
  logic [2:0] col_q, col_d;
  logic [7:0] xe_q, xe_d;
  logic [6:0] ye_q, ye_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;

  logic [8:0] x_sum, xe_full;
  logic [7:0] y_sum, ye_full;
  logic       empty;

  // Extra sum bit keeps x0+w-1 from wrapping before the clamp.
  always_comb begin
    x_sum   = {1'b0, x0_q} + {1'b0, w_q} - 9'd1;
    y_sum   = {1'b0, y0_q} + {1'b0, h_q} - 8'd1;
    xe_full = (x_sum > X_LAST) ? X_LAST : x_sum;
    ye_full = (y_sum > Y_LAST) ? Y_LAST : y_sum;
    empty   = (w_q == '0) || (h_q == '0) ||
              ({1'b0, x0_q} >= X_LIM) || ({1'b0, y0_q} >= Y_LIM);
  end

  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    w_d      = w_q;
    h_d      = h_q;
    col_d    = col_q;
    xe_d     = xe_q;
    ye_d     = ye_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = S_CLIP;
          if (cmd_clear) begin
            x0_d  = '0;
            y0_d  = '0;
            w_d   = X_LIM[7:0];
            h_d   = Y_LIM[6:0];
            col_d = CLEAR_COLOUR;
          end else begin
            x0_d  = cmd_x0;
            y0_d  = cmd_y0;
            w_d   = cmd_w;
            h_d   = cmd_h;
            col_d = cmd_colour;
          end
        end
      end
      S_CLIP: begin
        xe_d = xe_full[7:0];
        ye_d = ye_full[6:0];
        if (empty) begin
          state_d = S_DONE;
        end else begin
          x_d      = x0_q;
          y_d      = y0_q;
          colour_d = col_q;
          state_d  = S_DRAW;
        end
      end
      S_DRAW: begin
        if (!hold) begin
          if (x_q == xe_q) begin
            if (y_q == ye_q) begin
              state_d = S_DONE;
            end else begin
              x_d = x0_q;
              y_d = y_q + 7'd1;
            end
          end else begin
            x_d = x_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      col_q    <= '0;
      xe_q     <= '0;
      ye_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      w_q      <= w_d;
      h_q      <= h_d;
      col_q    <= col_d;
      xe_q     <= xe_d;
      ye_q     <= ye_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
    end
  end

  always_comb begin
    x         = x_q;
    y         = y_q;
    colour    = colour_q;
    plot      = (state_q == S_DRAW) && !hold;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    cmd_ready = (state_q == S_IDLE);
  end

endmodule

// File: tb/tb_rect_fill_ctrl.sv
// Directed bench for rect_fill_ctrl: cycle 0 is the handshake cycle, outputs sampled on negedge.
module tb_rect_fill_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       cmd_valid, cmd_ready, cmd_clear;
  logic [7:0] cmd_x0, cmd_w;
  logic [6:0] cmd_y0, cmd_h;
  logic [2:0] cmd_colour;
  logic       hold;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;

  rect_fill_ctrl #(
    .SCREEN_WIDTH (160),
    .SCREEN_HEIGHT(120),
    .CLEAR_COLOUR (3'b000)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_clear (cmd_clear),
    .cmd_x0    (cmd_x0),
    .cmd_y0    (cmd_y0),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_colour(cmd_colour),
    .hold      (hold),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int c;
    int px;
    int py;
    int col;
  } pix_t;

  pix_t pq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_c, n_done, ready_after, hold_bad, stray_ready, max_x, max_y;
  int   hold_lo = 0, hold_hi = -1, pulse_c = -1, hx = 0, hy = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive a command in the current (idle) cycle; the next posedge is the handshake edge.
  task automatic run_cmd(input logic clr, input logic [7:0] x0, input logic [6:0] y0,
                         input logic [7:0] w, input logic [6:0] h, input logic [2:0] col);
    cmd_clear  = clr;
    cmd_x0     = x0;
    cmd_y0     = y0;
    cmd_w      = w;
    cmd_h      = h;
    cmd_colour = col;
    cmd_valid  = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid  = 1'b0;
    cmd_clear  = 1'b0;
    cmd_x0     = 8'hAA;
    cmd_y0     = 7'h55;
    cmd_w      = 8'h33;
    cmd_h      = 7'h11;
    cmd_colour = 3'b111;
  endtask

  task automatic capture(input int maxc);
    pq.delete();
    done_c = -1; n_done = 0; ready_after = 0; hold_bad = 0; stray_ready = 0;
    max_x = 0; max_y = 0;
    for (int c = 1; c <= maxc; c++) begin
      hold = (c >= hold_lo) && (c <= hold_hi);
      if (c == pulse_c) begin
        cmd_valid = 1'b1; cmd_x0 = 8'd0; cmd_y0 = 7'd0; cmd_w = 8'd1; cmd_h = 7'd1;
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge clk);
      if (plot) begin
        pq.push_back('{c, int'(x), int'(y), int'(colour)});
        if (int'(x) > max_x) max_x = int'(x);
        if (int'(y) > max_y) max_y = int'(y);
      end
      if (hold && (plot || int'(x) != hx || int'(y) != hy)) hold_bad++;
      if (c == pulse_c && cmd_ready) stray_ready++;
      if (done) begin
        n_done++;
        if (done_c < 0) done_c = c;
      end
      if (done_c >= 0 && c == done_c + 1) begin
        ready_after = int'(cmd_ready);
        break;
      end
      @(posedge clk);
      #1;
    end
    hold      = 1'b0;
    cmd_valid = 1'b0;
  endtask

  task automatic check_seq(input string tag, input int x0, input int y0, input int xe,
                           input int ye, input int col, input int first_c, input bit consec);
    int i    = 0;
    int errs = 0;
    for (int yy = y0; yy <= ye; yy++) begin
      for (int xx = x0; xx <= xe; xx++) begin
        if (i >= pq.size()) errs++;
        else if (pq[i].px != xx || pq[i].py != yy || pq[i].col != col ||
                 (consec && pq[i].c != first_c + i)) errs++;
        i++;
      end
    end
    if (pq.size() > i) errs += pq.size() - i;
    check(tag, 32'(errs), 32'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_c[6];
    int errs;
    resetn = 1'b0; cmd_valid = 1'b0; cmd_clear = 1'b0; hold = 1'b0;
    cmd_x0 = '0; cmd_y0 = '0; cmd_w = '0; cmd_h = '0; cmd_colour = '0;
    #1;
    check("rst_x", 32'(x), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_colour", 32'(colour), 32'd0);
    check("rst_plot", 32'(plot), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Basic 3x2 fill
    run_cmd(1'b0, 8'd10, 7'd20, 8'd3, 7'd2, 3'b010);
    capture(30);
    check("t1_count", 32'(pq.size()), 32'd6);
    check_seq("t1_seq", 10, 20, 12, 21, 2, 2, 1'b1);
    check("t1_done_cycle", 32'(done_c), 32'd8);
    check("t1_done_pulses", 32'(n_done), 32'd1);
    check("t1_ready_after", 32'(ready_after), 32'd1);

    // Clipped at bottom-right corner
    run_cmd(1'b0, 8'd158, 7'd118, 8'd5, 7'd4, 3'b101);
    capture(30);
    check("t2_count", 32'(pq.size()), 32'd4);
    check_seq("t2_seq", 158, 118, 159, 119, 5, 2, 1'b1);
    check("t2_done_cycle", 32'(done_c), 32'd6);
    check("t2_max_x", 32'(max_x), 32'd159);
    check("t2_max_y", 32'(max_y), 32'd119);

    // Empty commands
    run_cmd(1'b0, 8'd10, 7'd10, 8'd0, 7'd5, 3'b001);
    capture(30);
    check("t3a_count", 32'(pq.size()), 32'd0);
    check("t3a_done_cycle", 32'(done_c), 32'd2);
    run_cmd(1'b0, 8'd160, 7'd5, 8'd4, 7'd4, 3'b001);
    capture(30);
    check("t3b_count", 32'(pq.size()), 32'd0);
    check("t3b_done_cycle", 32'(done_c), 32'd2);

    // Clear screen with garbage geometry/colour
    run_cmd(1'b1, 8'd200, 7'd100, 8'd7, 7'd3, 3'b111);
    capture(19300);
    check("t4_count", 32'(pq.size()), 32'd19200);
    check_seq("t4_seq", 0, 0, 159, 119, 0, 2, 1'b1);
    check("t4_done_cycle", 32'(done_c), 32'd19202);
    check("t4_last_x", 32'(pq.size() > 0 ? pq[pq.size()-1].px : -1), 32'd159);
    check("t4_last_y", 32'(pq.size() > 0 ? pq[pq.size()-1].py : -1), 32'd119);

    // Hold in cycles 3-5 plus a stray command pulse during DRAW
    hold_lo = 3; hold_hi = 5; hx = 11; hy = 20; pulse_c = 4;
    run_cmd(1'b0, 8'd10, 7'd20, 8'd3, 7'd2, 3'b010);
    capture(30);
    hold_lo = 0; hold_hi = -1; pulse_c = -1;
    check("t5_count", 32'(pq.size()), 32'd6);
    check_seq("t5_seq", 10, 20, 12, 21, 2, 0, 1'b0);
    exp_c = '{2, 6, 7, 8, 9, 10};
    errs = 0;
    for (int i = 0; i < 6; i++)
      if (i >= pq.size() || pq[i].c != exp_c[i]) errs++;
    check("t5_plot_cycles", 32'(errs), 32'd0);
    check("t5_hold_frozen", 32'(hold_bad), 32'd0);
    check("t5_stray_ready", 32'(stray_ready), 32'd0);
    check("t5_done_cycle", 32'(done_c), 32'd11);
    check("t5_done_pulses", 32'(n_done), 32'd1);

    // Asynchronous reset during the third pixel
    run_cmd(1'b0, 8'd10, 7'd20, 8'd3, 7'd2, 3'b010);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("t6_pre_plot", 32'(plot), 32'd1);
    check("t6_pre_x", 32'(x), 32'd12);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_rst_plot", 32'(plot), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_x", 32'(x), 32'd0);
    check("t6_rst_y", 32'(y), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("t6_ready", 32'(cmd_ready), 32'd1);
    run_cmd(1'b0, 8'd0, 7'd0, 8'd1, 7'd1, 3'b101);
    capture(30);
    check("t6_count", 32'(pq.size()), 32'd1);
    check_seq("t6_seq", 0, 0, 0, 0, 5, 2, 1'b1);
    check("t6_done_cycle", 32'(done_c), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
